tour_cmd_seq: RTL and testbench

Parametrised successor to the tour command sequencer. It converts each one-hot knight move from the tour solver into one L-shaped pair of movement commands (one vertical, one horizontal) and feeds them to cmd_proc through the same handshake as UART commands. The block takes over (usurps) the command path for the whole tour. It generalises board size and leg order, and adds invalid-move abort and an explicit tour_done.
It sits between UART_wrapper/tour solver and cmd_proc in KnightsTour.

---
 rtl/tour_cmd_pkg.sv | 64 ++++++
 rtl/knight_move_decode.sv | 38 +++
 rtl/tour_cmd_seq.sv | 191 +++++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_cmd_pkg.sv
// Shared constants, FSM state type and knight-move decode helpers for the tour command sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tour_cmd_pkg;

  // Command opcodes carried in cmd[15:12]
  localparam logic [3:0] OP_MOV    = 4'h2;
  localparam logic [3:0] OP_MOV_FF = 4'h3;
  localparam logic [3:0] OP_ABORT  = 4'hF;

  // Headings carried in cmd[11:4]
  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  // Response bytes toward the UART
  localparam logic [7:0] RESP_ACK  = 8'h5A;
  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEG1  = 3'd1,
    WAIT1 = 3'd2,
    LEG2  = 3'd3,
    WAIT2 = 3'd4
  } state_t;

  typedef struct packed {
    logic              vld;
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } move_delta_t;

  // One-hot move -> board displacement. Anything that is not exactly one
  // set bit (including all-zero) comes back with vld cleared.
  function automatic move_delta_t move_delta(input logic [7:0] mv);
    move_delta_t r;
    r.vld = 1'b1;
    r.dx  = 3'sd0;
    r.dy  = 3'sd0;
    case (mv)
      8'h01: begin r.dx =  3'sd1; r.dy =  3'sd2; end
      8'h02: begin r.dx = -3'sd1; r.dy =  3'sd2; end
      8'h04: begin r.dx = -3'sd2; r.dy =  3'sd1; end
      8'h08: begin r.dx = -3'sd2; r.dy = -3'sd1; end
      8'h10: begin r.dx = -3'sd1; r.dy = -3'sd2; end
      8'h20: begin r.dx =  3'sd1; r.dy = -3'sd2; end
      8'h40: begin r.dx =  3'sd2; r.dy = -3'sd1; end
      8'h80: begin r.dx =  3'sd2; r.dy =  3'sd1; end
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // Magnitude of a displacement as a 4-bit square count
  function automatic logic [3:0] delta_mag(input logic signed [2:0] v);
    logic [2:0] a;
    a = v[2] ? 3'(-v) : 3'(v);
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal command words.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
//   move     in  8   one-hot move
//   vert_cmd out 16  vertical leg command (opcode reflects leg order)
//   horz_cmd out 16  horizontal leg command (opcode reflects leg order)
//   vld      out 1   move was exactly one-hot
module knight_move_decode
  import tour_cmd_pkg::*;
#(
  parameter bit VERT_FIRST = 1'b1
) (
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        vld
);

  move_delta_t d;
  logic [3:0]  v_op;
  logic [3:0]  h_op;
  logic [7:0]  v_hdg;
  logic [7:0]  h_hdg;

  always_comb begin
    d     = move_delta(move);
    vld   = d.vld;
    // The leg issued first is a plain move; the second one closes the
    // L-shape and carries the fanfare opcode.
    v_op  = VERT_FIRST ? OP_MOV : OP_MOV_FF;
    h_op  = VERT_FIRST ? OP_MOV_FF : OP_MOV;
    v_hdg = d.dy[2] ? HDG_SOUTH : HDG_NORTH;
    h_hdg = d.dx[2] ? HDG_WEST : HDG_EAST;
    vert_cmd = {v_op, v_hdg, delta_mag(d.dy)};
    horz_cmd = {h_op, h_hdg, delta_mag(d.dx)};
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: replays solver moves as L-shaped command pairs to cmd_proc.
// Latency: UART pass-through is combinational; each leg raises cmd_rdy one cycle after the leg starts.
// Backpressure: a leg is held until clr_cmd_rdy, the next leg waits for send_resp from cmd_proc.
// Optional build macro TOUR_CMD_SEQ_ABORT_EN: a UART command with opcode 4'hF aborts a running tour.
//   clk, rst                 clock, synchronous active-high reset
//   start_tour     in  1     solver pulse: move list ready
//   move           in  8     one-hot move at mv_indx
//   mv_indx        out IDX_W index of the current move
//   cmd_UART       in  16    / cmd_rdy_UART in 1  : command from UART_wrapper
//   cmd            out 16    / cmd_rdy      out 1 : muxed command to cmd_proc
//   clr_cmd_rdy    in  1     cmd_proc consumed cmd
//   send_resp      in  1     cmd_proc finished current leg
//   resp           out 8     response byte to UART
//   usurp          out 1     sequencer owns the command path
//   tour_done      out 1     one-cycle pulse after the final leg
module tour_cmd_seq
  import tour_cmd_pkg::*;
#(
  parameter  int BOARD_SIZE = 5,
  parameter  bit VERT_FIRST = 1'b1,
  localparam int NUM_MOVES  = BOARD_SIZE * BOARD_SIZE - 1,
  localparam int IDX_W      = $clog2(NUM_MOVES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             usurp,
  output logic             tour_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic             usurp_q, usurp_d;
  logic             tour_done_q, tour_done_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [7:0]       leg_q, leg_d;

  logic [7:0]  dec_move;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        dec_vld;
  logic [15:0] first_cmd;
  logic [15:0] second_cmd;
  logic [15:0] seq_cmd;
  logic        clr_ok;
  logic        send_ok;

  // While the first leg is pending the decoder looks straight at solver
  // memory; afterwards it looks at the captured move so the second leg is
  // independent of whatever the memory presents later.
  always_comb begin
    dec_move = (state_q == LEG1) ? move : leg_q;
  end

  knight_move_decode #(
    .VERT_FIRST (VERT_FIRST)
  ) u_decode (
    .move     (dec_move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .vld      (dec_vld)
  );

  always_comb begin
    first_cmd  = VERT_FIRST ? vert_cmd : horz_cmd;
    second_cmd = VERT_FIRST ? horz_cmd : vert_cmd;
    seq_cmd    = ((state_q == LEG1) || (state_q == WAIT1)) ? first_cmd : second_cmd;
  end

  always_comb begin
    state_d     = state_q;
    mv_indx_d   = mv_indx_q;
    usurp_d     = usurp_q;
    tour_done_d = 1'b0;
    cmd_rdy_d   = cmd_rdy_q;
    leg_d       = leg_q;
    resp        = RESP_IDLE;

    // A consume is only meaningful once cmd_rdy is visible; a completion
    // arriving together with a consume is dropped.
    clr_ok  = clr_cmd_rdy && cmd_rdy_q;
    send_ok = send_resp && !clr_cmd_rdy;

    case (state_q)
      IDLE: begin
        if (start_tour) begin
          mv_indx_d = '0;
          usurp_d   = 1'b1;
          state_d   = LEG1;
        end
      end
      LEG1: begin
        if (!dec_vld) begin
          resp      = RESP_ERR;
          usurp_d   = 1'b0;
          cmd_rdy_d = 1'b0;
          state_d   = IDLE;
        end else if (clr_ok) begin
          cmd_rdy_d = 1'b0;
          leg_d     = move;
          state_d   = WAIT1;
        end else begin
          cmd_rdy_d = 1'b1;
        end
      end
      WAIT1: begin
        if (send_ok) begin
          state_d = LEG2;
        end
      end
      LEG2: begin
        if (clr_ok) begin
          cmd_rdy_d = 1'b0;
          state_d   = WAIT2;
        end else begin
          cmd_rdy_d = 1'b1;
        end
      end
      WAIT2: begin
        if (send_ok) begin
          if (mv_indx_q == LAST_IDX) begin
            tour_done_d = 1'b1;
            usurp_d     = 1'b0;
            state_d     = IDLE;
          end else begin
            resp      = RESP_ACK;
            mv_indx_d = mv_indx_q + IDX_W'(1);
            state_d   = LEG1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        usurp_d   = 1'b0;
        cmd_rdy_d = 1'b0;
      end
    endcase

`ifdef TOUR_CMD_SEQ_ABORT_EN
    // Abort wins over any leg in flight; cmd_proc completes its current
    // move on its own, so nothing here waits for it.
    if (usurp_q && cmd_rdy_UART && (cmd_UART[15:12] == OP_ABORT)) begin
      resp        = RESP_ERR;
      usurp_d     = 1'b0;
      cmd_rdy_d   = 1'b0;
      tour_done_d = 1'b0;
      state_d     = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mv_indx_q   <= '0;
      usurp_q     <= 1'b0;
      tour_done_q <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      leg_q       <= '0;
    end else begin
      state_q     <= state_d;
      mv_indx_q   <= mv_indx_d;
      usurp_q     <= usurp_d;
      tour_done_q <= tour_done_d;
      cmd_rdy_q   <= cmd_rdy_d;
      leg_q       <= leg_d;
    end
  end

  // Outside a tour the UART owns the path with no added latency.
  always_comb begin
    cmd     = usurp_q ? seq_cmd : cmd_UART;
    cmd_rdy = usurp_q ? cmd_rdy_q : cmd_rdy_UART;
  end

  assign mv_indx   = mv_indx_q;
  assign usurp     = usurp_q;
  assign tour_done = tour_done_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
module tb_tour_cmd_seq;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_tour;
  logic [7:0]       move;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy;
  logic             send_resp;

  logic [IDX_W-1:0] mv_indx, mv_indx_h;
  logic [15:0]      cmd, cmd_h;
  logic             cmd_rdy, cmd_rdy_h;
  logic [7:0]       resp, resp_h;
  logic             usurp, usurp_h;
  logic             tour_done, tour_done_h;

  logic [7:0]       mv_mem [0:23];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] d1;  // vertical-first instance, first leg
    logic [15:0] d2;  // vertical-first instance, second leg
    logic [15:0] h1;  // horizontal-first instance, first leg
    logic [15:0] h2;  // horizontal-first instance, second leg
  } mv_vec_t;

  typedef struct {
    logic [15:0] cu;
    logic        ru;
    logic [15:0] ec;
    logic        er;
  } uart_vec_t;

  mv_vec_t   vt [8];
  uart_vec_t ut [5];

  always #5 clk = ~clk;

  assign move = mv_mem[mv_indx];

  tour_cmd_seq #(.BOARD_SIZE(5), .VERT_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .usurp        (usurp),
    .tour_done    (tour_done)
  );

  tour_cmd_seq #(.BOARD_SIZE(5), .VERT_FIRST(1'b0)) dut_h (
    .clk          (clk),
    .rst          (rst),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx_h),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd_h),
    .cmd_rdy      (cmd_rdy_h),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp_h),
    .usurp        (usurp_h),
    .tour_done    (tour_done_h)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " cmd_rdy"}, 32'(cmd_rdy), 32'd1);
  endtask

  // One full move: two legs, each consumed and completed.
  task automatic do_move(input int i, input bit last);
    int e = i % 8;
    wait_rdy("leg1");
    chk("leg1 cmd", 32'(cmd), 32'(vt[e].d1));
    chk("leg1 cmd_h", 32'(cmd_h), 32'(vt[e].h1));
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
    chk("wait1 cmd_rdy", 32'(cmd_rdy), 32'd0);
    send_resp = 1'b1; #1;
    chk("wait1 resp", 32'(resp), 32'hA5);
    tick(); send_resp = 1'b0;
    wait_rdy("leg2");
    chk("leg2 cmd", 32'(cmd), 32'(vt[e].d2));
    chk("leg2 cmd_h", 32'(cmd_h), 32'(vt[e].h2));
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
    send_resp = 1'b1; #1;
    chk("wait2 resp", 32'(resp), last ? 32'hA5 : 32'h5A);
    tick(); send_resp = 1'b0; #1;
    if (last) begin
      chk("done pulse", 32'(tour_done), 32'd1);
      chk("done usurp", 32'(usurp), 32'd0);
      chk("done mv_indx", 32'(mv_indx), 32'd23);
      tick();
      chk("done pulse end", 32'(tour_done), 32'd0);
      chk("done mv_indx hold", 32'(mv_indx), 32'd23);
    end else begin
      chk("mv_indx step", 32'(mv_indx), 32'(i + 1));
      chk("usurp held", 32'(usurp), 32'd1);
      chk("no done", 32'(tour_done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{8'h01, 16'h2002, 16'h3BF1, 16'h2BF1, 16'h3002};
    vt[1] = '{8'h02, 16'h2002, 16'h33F1, 16'h23F1, 16'h3002};
    vt[2] = '{8'h04, 16'h2001, 16'h33F2, 16'h23F2, 16'h3001};
    vt[3] = '{8'h08, 16'h27F1, 16'h33F2, 16'h23F2, 16'h37F1};
    vt[4] = '{8'h10, 16'h27F2, 16'h33F1, 16'h23F1, 16'h37F2};
    vt[5] = '{8'h20, 16'h27F2, 16'h3BF1, 16'h2BF1, 16'h37F2};
    vt[6] = '{8'h40, 16'h27F1, 16'h3BF2, 16'h2BF2, 16'h37F1};
    vt[7] = '{8'h80, 16'h2001, 16'h3BF2, 16'h2BF2, 16'h3001};

    ut[0] = '{16'h0000, 1'b1, 16'h0000, 1'b1};
    ut[1] = '{16'h1234, 1'b0, 16'h1234, 1'b0};
    ut[2] = '{16'hF0F0, 1'b1, 16'hF0F0, 1'b1};
    ut[3] = '{16'h2BF1, 1'b1, 16'h2BF1, 1'b1};
    ut[4] = '{16'hFFFF, 1'b0, 16'hFFFF, 1'b0};

    for (int i = 0; i < 24; i++) mv_mem[i] = vt[i % 8].mv;

    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst usurp", 32'(usurp), 32'd0);
    chk("rst mv_indx", 32'(mv_indx), 32'd0);
    chk("rst tour_done", 32'(tour_done), 32'd0);
    chk("rst resp", 32'(resp), 32'hA5);
    chk("rst cmd_rdy", 32'(cmd_rdy), 32'd0);

    // UART pass-through, no clock between drive and check
    for (int i = 0; i < 5; i++) begin
      cmd_UART = ut[i].cu; cmd_rdy_UART = ut[i].ru; #1;
      chk("uart cmd", 32'(cmd), 32'(ut[i].ec));
      chk("uart cmd_rdy", 32'(cmd_rdy), 32'(ut[i].er));
      chk("uart usurp", 32'(usurp), 32'd0);
    end
    cmd_rdy_UART = 1'b0;

    // Full 24-move tour
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("start usurp", 32'(usurp), 32'd1);
    chk("start mv_indx", 32'(mv_indx), 32'd0);
    for (int i = 0; i < 24; i++) do_move(i, i == 23);
    cmd_UART = 16'h1111; cmd_rdy_UART = 1'b1; #1;
    chk("post tour cmd", 32'(cmd), 32'h1111);
    chk("post tour cmd_rdy", 32'(cmd_rdy), 32'd1);
    cmd_rdy_UART = 1'b0;

    // Non-one-hot move at index 5
    mv_mem[5] = 8'h03;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    for (int i = 0; i < 5; i++) do_move(i, 1'b0);
    #1;
    chk("bad resp", 32'(resp), 32'hEE);
    chk("bad cmd_rdy", 32'(cmd_rdy), 32'd0);
    tick();
    chk("bad usurp", 32'(usurp), 32'd0);
    chk("bad no done", 32'(tour_done), 32'd0);
    chk("bad resp after", 32'(resp), 32'hA5);
    tick();
    chk("bad no done later", 32'(tour_done), 32'd0);
    mv_mem[5] = vt[5].mv;

    // start_tour ignored mid-tour, simultaneous clr/send, reset in WAIT2
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    do_move(0, 1'b0);
    wait_rdy("m1 leg1");
    chk("m1 leg1 cmd", 32'(cmd), 32'(vt[1].d1));
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    chk("restart ignored mv_indx", 32'(mv_indx), 32'd1);
    chk("restart ignored cmd_rdy", 32'(cmd_rdy), 32'd0);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    wait_rdy("m1 leg2");
    chk("m1 leg2 cmd", 32'(cmd), 32'(vt[1].d2));
`ifndef TOUR_CMD_SEQ_ABORT_EN
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1; #1;
    chk("uart ignored cmd", 32'(cmd), 32'(vt[1].d2));
    chk("uart ignored resp", 32'(resp), 32'hA5);
    tick(); cmd_rdy_UART = 1'b0; #1;
    chk("uart ignored usurp", 32'(usurp), 32'd1);
    chk("uart ignored cmd_rdy", 32'(cmd_rdy), 32'd1);
`endif
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick();
    #1;
    chk("wait2 both resp", 32'(resp), 32'hA5);
    tick(); clr_cmd_rdy = 1'b0; send_resp = 1'b0; #1;
    chk("wait2 both mv_indx", 32'(mv_indx), 32'd1);
    chk("wait2 both cmd_rdy", 32'(cmd_rdy), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
    chk("midrst usurp", 32'(usurp), 32'd0);
    chk("midrst mv_indx", 32'(mv_indx), 32'd0);
    chk("midrst cmd", 32'(cmd), 32'h1234);
    chk("midrst cmd_rdy", 32'(cmd_rdy), 32'd1);
    cmd_rdy_UART = 1'b0;

`ifdef TOUR_CMD_SEQ_ABORT_EN
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    wait_rdy("ab leg1");
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    wait_rdy("ab leg2");
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1; #1;
    chk("abort resp", 32'(resp), 32'hEE);
    tick(); #1;
    chk("abort usurp", 32'(usurp), 32'd0);
    chk("abort cmd", 32'(cmd), 32'hF000);
    chk("abort no done", 32'(tour_done), 32'd0);
    cmd_rdy_UART = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
